// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the 7-segment scan reader.
// Patterns are active-low, bit0=a ... bit6=g.
package seg7_pkg;

    typedef logic [6:0] seg7_t;
    typedef logic [3:0] bcd_t;

    localparam seg7_t SEG_0     = 7'h40;
    localparam seg7_t SEG_1     = 7'h79;
    localparam seg7_t SEG_2     = 7'h24;
    localparam seg7_t SEG_3     = 7'h30;
    localparam seg7_t SEG_4     = 7'h19;
    localparam seg7_t SEG_5     = 7'h12;
    localparam seg7_t SEG_6     = 7'h02;
    localparam seg7_t SEG_7     = 7'h78;
    localparam seg7_t SEG_8     = 7'h00;
    localparam seg7_t SEG_9     = 7'h10;
    localparam seg7_t SEG_BLANK = 7'h7F;
    localparam bcd_t  BCD_BLANK = 4'hF;

endpackage

// File: rtl/seg7_scan_reader_if.sv
// Bus between the multiplexed display side (master) and the scan reader (slave).
interface seg7_scan_reader_if #(
    parameter int NUM_DIGITS = 2
);
    import seg7_pkg::*;

    seg7_t                   seg_n;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic                    strobe;
    logic                    err_clr;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic                    valid;
    logic                    update;
    logic                    pattern_err;

    modport master (
        output seg_n, dig_sel, strobe, err_clr,
        input  bcd, valid, update, pattern_err
    );

    modport slave (
        input  seg_n, dig_sel, strobe, err_clr,
        output bcd, valid, update, pattern_err
    );

endinterface

// File: rtl/seg7_to_bcd.sv
// Combinational segment-pattern decoder. With SEG_BLANK_EN defined the
// all-off pattern decodes to BCD_BLANK; otherwise it is reported as a miss.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  seg7_t seg_n,
    output logic  hit,
    output bcd_t  bcd
);

    // Pattern lookup; anything outside the table is a miss
    always_comb begin
        hit = 1'b1;
        bcd = 4'd0;
        case (seg_n)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
`ifdef SEG_BLANK_EN
            SEG_BLANK: bcd = BCD_BLANK;
`endif
            default: begin
                hit = 1'b0;
                bcd = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers per-digit BCD values from a multiplexed active-low 7-segment bus,
// committing a digit only after STABLE_SCANS identical samples. Honours SEG_BLANK_EN.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int STABLE_SCANS = 3
)(
    input logic               clk,
    input logic               rst_n,
    seg7_scan_reader_if.slave bus
);

    localparam logic [3:0] STABLE_CNT = 4'(STABLE_SCANS);

    logic                    hit_s;
    bcd_t                    dec_s;
    logic                    sample_s;
    logic                    set_err_s;
    logic                    change_s;
    bcd_t                    cand_r     [NUM_DIGITS];
    logic [3:0]              cnt_r      [NUM_DIGITS];
    bcd_t                    cand_nxt_s [NUM_DIGITS];
    logic [3:0]              cnt_nxt_s  [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   commit_s;
    logic [NUM_DIGITS-1:0]   seen_r;
    logic [NUM_DIGITS-1:0]   seen_nxt_s;
    logic [4*NUM_DIGITS-1:0] bcd_r;
    logic [4*NUM_DIGITS-1:0] bcd_nxt_s;
    logic                    valid_r;
    logic                    update_r;
    logic                    err_r;

    seg7_to_bcd u_dec (
        .seg_n (bus.seg_n),
        .hit   (hit_s),
        .bcd   (dec_s)
    );

    // Stability filter and commit decision for the selected digit
    always_comb begin
        sample_s   = bus.strobe && $onehot(bus.dig_sel);
        set_err_s  = sample_s && !hit_s;
        change_s   = 1'b0;
        seen_nxt_s = seen_r;
        bcd_nxt_s  = bcd_r;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cand_nxt_s[i] = cand_r[i];
            cnt_nxt_s[i]  = cnt_r[i];
            commit_s[i]   = 1'b0;
            if (sample_s && bus.dig_sel[i]) begin
                if (!hit_s) begin
                    cnt_nxt_s[i] = 4'd0;
                end else if (dec_s == cand_r[i]) begin
                    if (cnt_r[i] < STABLE_CNT) begin
                        cnt_nxt_s[i] = cnt_r[i] + 4'd1;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i];
                    end
                end else begin
                    cand_nxt_s[i] = dec_s;
                    cnt_nxt_s[i]  = 4'd1;
                end
                commit_s[i] = hit_s && (cnt_nxt_s[i] == STABLE_CNT);
            end else begin
                commit_s[i] = 1'b0;
            end
            // A saturated re-commit of an already-seen value is silent
            if (commit_s[i] && ((cand_nxt_s[i] != bcd_r[4*i +: 4]) || !seen_r[i])) begin
                bcd_nxt_s[4*i +: 4] = cand_nxt_s[i];
                seen_nxt_s[i]       = 1'b1;
                change_s            = 1'b1;
            end else begin
                bcd_nxt_s[4*i +: 4] = bcd_r[4*i +: 4];
            end
        end
    end

    // Filter state, committed digits and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cand_r[i] <= 4'd0;
                cnt_r[i]  <= 4'd0;
            end
            seen_r   <= '0;
            bcd_r    <= '0;
            valid_r  <= 1'b0;
            update_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cand_r[i] <= cand_nxt_s[i];
                cnt_r[i]  <= cnt_nxt_s[i];
            end
            seen_r   <= seen_nxt_s;
            bcd_r    <= bcd_nxt_s;
            valid_r  <= &seen_nxt_s;
            update_r <= change_s;
            if (set_err_s) begin
                err_r <= 1'b1;
            end else if (bus.err_clr) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign bus.bcd         = bcd_r;
    assign bus.valid       = valid_r;
    assign bus.update      = update_r;
    assign bus.pattern_err = err_r;

endmodule
